active_mask_gatherer: RTL and testbench
=======================================

Name: active_mask_gatherer

Overview:
- Inverse of the dispatcher's mask split. Collects four 64-bit per-lane masks from the four next_tid_logic lanes, for example completion or exit masks.
- Scatters each lane mask back into 256-bit chunk positions according to the unrolling factor, then emits one 256-bit chunk per round over a valid/ready handshake.
- Sits between the per-lane thread-completion logic and the warp-level active-mask writeback. Iterates over NUM_CHUNKS chunks per gather operation.

Parameters:
- NUM_CHUNKS, default 4: number of 256-bit chunks per gather operation; must be ≥1.
- IDX_W, default $clog2(NUM_CHUNKS) with a minimum of 1: width of chunk_idx.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a gather operation; sampled only in IDLE
- unrolling_factor  in  2  0=x1, 1=x2, 2=x4; latched at accepted start
- lane_valid  in  4  per-lane mask valid
- lane_ready  out  4  per-lane mask ready
- lane_mask0 .. lane_mask3  in  64 each  per-lane masks
- chunk_valid  out  1  assembled chunk valid
- chunk_ready  in  1  downstream accepts chunk
- chunk_mask  out  256  assembled chunk
- chunk_idx  out  IDX_W  index of the current chunk
- last_chunk  out  1  high with chunk_valid on chunk NUM_CHUNKS-1
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0. FSM returns to IDLE, accumulator is cleared, received flags are cleared, chunk counter is 0, latched factor is 0. Reset asserted mid-operation aborts the operation with no partial chunk emitted.
- IDLE state:
  - start=1 latches unrolling_factor. A value of 2'b11 is latched as 2'b00.
  - Clears accumulator and received flags, sets chunk_idx=0, moves to COLLECT.
  - lane_ready=0 while in IDLE.
- COLLECT state:
  - lane_ready[k] = !received[k].
  - A handshake on lane k (lane_valid[k] & lane_ready[k]) writes lane_maskk into the accumulator and sets received[k].
  - Any subset of lanes may handshake in the same cycle.
  - When all four received flags are set (counting same-cycle handshakes), the FSM moves to OUTPUT on the next edge. chunk_valid therefore rises exactly 1 cycle after the final lane handshake.
- Scatter rules (latched factor uf, output bit positions):
  - uf=0: lane k maps to chunk[64k +: 64].
  - uf=1, for i=0..3: lane0 16-bit group i maps to [32i +: 16]; lane1 to [32i+16 +: 16]; lane2 to [128+32i +: 16]; lane3 to [128+32i+16 +: 16].
  - uf=2, for i=0..7: lane k 8-bit group i maps to [32i+8k +: 8].
- OUTPUT state:
  - chunk_valid=1. chunk_mask, chunk_idx and last_chunk are held stable until chunk_ready.
  - lane_ready=0 while in OUTPUT.
  - On chunk_ready with chunk_idx==NUM_CHUNKS-1: go to IDLE; chunk_valid drops the next cycle.
  - On chunk_ready otherwise: chunk_idx+1, accumulator and received flags cleared, back to COLLECT. No idle gap beyond that one edge.
- start asserted outside IDLE is ignored. unrolling_factor changes outside IDLE have no effect.
- The accumulator is fully overwritten per lane slot, not ORed. Each slot is written exactly once per chunk.
- Back-pressure: chunk_ready held low stalls indefinitely. The lanes see lane_ready=0 for the whole stall.

Optional Feature:
- Macro: ACTIVE_MASK_GATHER_ERR_EN.
- Defined:
  - Adds output port err (1 bit), reset to 0.
  - err is a sticky flag set by any of: lane_valid nonzero while in IDLE; start accepted with unrolling_factor==2'b11.
  - err clears only on reset.
  - The 2'b11 value is still latched as 2'b00.
- Undefined: no err port, and these conditions are silently tolerated.

Test Plan:
- uf=0, NUM_CHUNKS=1:
  - Stimulus: start; all lanes valid in one cycle with lane_maskk=64'h1111..1*(k+1).
  - Response: chunk_valid 1 cycle later; chunk_mask={lane3,lane2,lane1,lane0}; last_chunk=1; busy drops after chunk_ready.
- uf=2:
  - Stimulus: lane0=64'hFF, others 0.
  - Response: chunk_mask=256'hFF, i.e. bits 0-7 only.
  - Stimulus: lane1=64'hFF00.
  - Response: bits 40-47 set.
- uf=1:
  - Stimulus: lanes arrive staggered (lane2 cycle 0, lane0 cycle 3, lane3 cycle 5, lane1 cycle 6).
  - Response: lane_ready[k] deasserts after its handshake; chunk_valid at cycle 7; lane3=64'hFFFF maps to bits 144-159.
- NUM_CHUNKS=4, chunk_ready held low 10 cycles per chunk:
  - Response: chunk_mask stable while stalled; chunk_idx sequence 0,1,2,3; last_chunk only at idx 3; return to IDLE after that.
- Reset mid-collect:
  - Stimulus: rst_n low after 2 lanes have been received.
  - Response: all outputs 0 immediately. A fresh start then requires all 4 lanes again.
- With ACTIVE_MASK_GATHER_ERR_EN:
  - Stimulus: start with uf=2'b11.
  - Response: err=1 stays set; scatter follows the uf=0 rules.

Source files
------------

// File: rtl/active_mask_gatherer.sv
`default_nettype none
// ============================================================================
//  Module   : active_mask_gatherer
//  Purpose  : Collects four 64-bit per-lane masks from the next_tid_logic
//             lanes, scatters them into a 256-bit chunk according to the
//             latched unrolling factor, and emits NUM_CHUNKS chunks per
//             gather operation over a valid/ready handshake.
//  Options  : define ACTIVE_MASK_GATHER_ERR_EN to add a sticky 'err' output
//             flagging lane activity in IDLE or a start with factor 2'b11.
//  Revision : 1.0 - initial release
// ============================================================================
module active_mask_gatherer #(
    parameter int NUM_CHUNKS = 4,
    parameter int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         unrolling_factor,
    input  logic [3:0]         lane_valid,
    output logic [3:0]         lane_ready,
    input  logic [63:0]        lane_mask0,
    input  logic [63:0]        lane_mask1,
    input  logic [63:0]        lane_mask2,
    input  logic [63:0]        lane_mask3,
    output logic               chunk_valid,
    input  logic               chunk_ready,
    output logic [255:0]       chunk_mask,
    output logic [IDX_W-1:0]   chunk_idx,
    output logic               last_chunk,
    output logic               busy
`ifdef ACTIVE_MASK_GATHER_ERR_EN
    ,
    output logic               err
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [1:0]         uf;
    logic [255:0]       acc;
    logic [255:0]       acc_nxt;
    logic [3:0]         received;
    logic [IDX_W-1:0]   idx;

    logic [3:0]         hs;
    logic               all_recv;
    logic               is_last;

    logic [63:0]        lanes [4];
    logic [255:0]       scat_x1;
    logic [255:0]       scat_x2;
    logic [255:0]       scat_x4;
    logic [255:0]       scat_sel;
    logic [255:0]       wmask;

    assign lanes[0] = lane_mask0;
    assign lanes[1] = lane_mask1;
    assign lanes[2] = lane_mask2;
    assign lanes[3] = lane_mask3;

    assign hs       = lane_valid & lane_ready;
    assign all_recv = &(received | hs);
    assign is_last  = (idx == IDX_W'(NUM_CHUNKS - 1));

    // Each factor's placement tiles all 256 bits exactly once across lanes,
    // so the three scattered images can be built as fully driven vectors.
    assign scat_x1 = {lane_mask3, lane_mask2, lane_mask1, lane_mask0};

    for (genvar k = 0; k < 4; k++) begin : g_lane
        for (genvar i = 0; i < 4; i++) begin : g_x2
            assign scat_x2[(k/2)*128 + 32*i + (k%2)*16 +: 16] = lanes[k][16*i +: 16];
        end
        for (genvar i = 0; i < 8; i++) begin : g_x4
            assign scat_x4[32*i + 8*k +: 8] = lanes[k][8*i +: 8];
        end
    end

    // Bit positions owned by lane k under factor u.
    function automatic logic [255:0] slot_of(input logic [1:0] u, input int k);
        logic [255:0] s;
        s = '0;
        case (u)
            2'd1: for (int i = 0; i < 4; i++) s[(k/2)*128 + 32*i + (k%2)*16 +: 16] = '1;
            2'd2: for (int i = 0; i < 8; i++) s[32*i + 8*k +: 8] = '1;
            default: s[64*k +: 64] = '1;
        endcase
        return s;
    endfunction

    // Merge every handshaking lane's slots into the accumulator (overwrite).
    always_comb begin
        wmask = '0;
        for (int k = 0; k < 4; k++) begin
            if (hs[k]) wmask = wmask | slot_of(uf, k);
        end
        case (uf)
            2'd1:    scat_sel = scat_x2;
            2'd2:    scat_sel = scat_x4;
            default: scat_sel = scat_x1;
        endcase
        acc_nxt = (acc & ~wmask) | (scat_sel & wmask);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COLLECT;
            COLLECT: if (all_recv) state_nxt = OUTPUT;
            OUTPUT:  if (chunk_ready) state_nxt = is_last ? IDLE : COLLECT;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: factor latch, accumulator, received flags, chunk counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uf       <= 2'd0;
            acc      <= '0;
            received <= 4'd0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        uf       <= (unrolling_factor == 2'b11) ? 2'b00 : unrolling_factor;
                        acc      <= '0;
                        received <= 4'd0;
                        idx      <= '0;
                    end
                end
                COLLECT: begin
                    acc      <= acc_nxt;
                    received <= received | hs;
                end
                OUTPUT: begin
                    if (chunk_ready) begin
                        acc      <= '0;
                        received <= 4'd0;
                        idx      <= is_last ? '0 : idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ACTIVE_MASK_GATHER_ERR_EN
    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == IDLE &&
                     ((|lane_valid) || (start && unrolling_factor == 2'b11))) begin
            err <= 1'b1;
        end
    end
`endif

    assign chunk_valid = (state == OUTPUT);
    assign chunk_mask  = chunk_valid ? acc : '0;
    assign chunk_idx   = idx;
    assign last_chunk  = chunk_valid & is_last;
    assign busy        = (state != IDLE);
    assign lane_ready  = (state == COLLECT) ? ~received : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_active_mask_gatherer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_active_mask_gatherer
//  Purpose  : Self-checking bench for active_mask_gatherer (NUM_CHUNKS=4)
//             using randomized lane arrival and a bit-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_active_mask_gatherer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   unrolling_factor = 2'd0;
    logic [3:0]   lane_valid = 4'd0;
    logic [3:0]   lane_ready;
    logic [63:0]  lane_mask0 = '0;
    logic [63:0]  lane_mask1 = '0;
    logic [63:0]  lane_mask2 = '0;
    logic [63:0]  lane_mask3 = '0;
    logic         chunk_valid;
    logic         chunk_ready = 1'b0;
    logic [255:0] chunk_mask;
    logic [1:0]   chunk_idx;
    logic         last_chunk;
    logic         busy;
`ifdef ACTIVE_MASK_GATHER_ERR_EN
    logic         err;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0]  cur_mask [4];
    int           cur_arr  [4];

    active_mask_gatherer #(.NUM_CHUNKS(N)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .unrolling_factor (unrolling_factor),
        .lane_valid       (lane_valid),
        .lane_ready       (lane_ready),
        .lane_mask0       (lane_mask0),
        .lane_mask1       (lane_mask1),
        .lane_mask2       (lane_mask2),
        .lane_mask3       (lane_mask3),
        .chunk_valid      (chunk_valid),
        .chunk_ready      (chunk_ready),
        .chunk_mask       (chunk_mask),
        .chunk_idx        (chunk_idx),
        .last_chunk       (last_chunk),
        .busy             (busy)
`ifdef ACTIVE_MASK_GATHER_ERR_EN
        ,
        .err              (err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Reference: for every output bit, find which lane/bit the rules put there.
    function automatic logic [255:0] model(input logic [1:0] u);
        logic [255:0] r;
        int lane, bt, h, w, i;
        r = '0;
        for (int b = 0; b < 256; b++) begin
            case (u)
                2'd1: begin
                    h = b / 128; i = (b % 128) / 32; w = b % 32;
                    lane = 2*h + w/16; bt = 16*i + w%16;
                end
                2'd2: begin
                    i = b / 32; w = b % 32;
                    lane = w / 8; bt = 8*i + w%8;
                end
                default: begin
                    lane = b / 64; bt = b % 64;
                end
            endcase
            r[b] = cur_mask[lane][bt];
        end
        return r;
    endfunction

    function automatic logic [1:0] eff_uf(input logic [1:0] u);
        return (u == 2'b11) ? 2'b00 : u;
    endfunction

    task automatic set_lane(input int k, input logic [63:0] v);
        case (k)
            0: lane_mask0 = v;
            1: lane_mask1 = v;
            2: lane_mask2 = v;
            default: lane_mask3 = v;
        endcase
    endtask

    task automatic rand_chunk();
        for (int k = 0; k < 4; k++) begin
            cur_mask[k] = {$urandom, $urandom};
            cur_arr[k]  = $urandom_range(0, 4);
        end
    endtask

    task automatic do_start(input logic [1:0] u);
        start = 1'b1; unrolling_factor = u; lane_valid = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || chunk_idx !== 2'd0 || lane_ready !== 4'hF || chunk_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_accept: busy=%b idx=%0d lane_ready=%b valid=%b required 1/0/1111/0",
                     busy, chunk_idx, lane_ready, chunk_valid);
        end
    endtask

    // Feed one chunk (cur_mask/cur_arr), then hold it off for 'stall' cycles.
    task automatic collect_and_emit(input int j, input logic [1:0] u, input int stall,
                                    input bit use_dir, input logic [255:0] dir_exp);
        logic [3:0]   recv;
        logic [255:0] exp;
        bit           done;
        recv = 4'd0;
        exp  = model(u);
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            checks++;
            if (&recv) begin
                if (chunk_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL valid_rise chunk %0d: chunk_valid=%b required 1", j, chunk_valid);
                end
                done = 1'b1;
            end else begin
                if (chunk_valid !== 1'b0 || lane_ready !== ~recv) begin
                    errors++;
                    $display("FAIL collect chunk %0d cyc %0d: lane_ready=%b valid=%b required %b/0",
                             j, c, lane_ready, chunk_valid, ~recv);
                end
                for (int k = 0; k < 4; k++) begin
                    if (!recv[k] && c >= cur_arr[k]) begin
                        lane_valid[k] = 1'b1;
                        set_lane(k, cur_mask[k]);
                    end else begin
                        lane_valid[k] = recv[k] ? 1'($urandom % 2) : 1'b0;
                        set_lane(k, {$urandom, $urandom});
                    end
                end
                start = 1'($urandom % 2);
                unrolling_factor = 2'($urandom);
                recv = recv | (lane_valid & ~recv);
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL collect_timeout chunk %0d: chunk_valid=%b required 1", j, chunk_valid);
        end
        for (int s = 0; s <= stall; s++) begin
            checks++;
            if (chunk_valid !== 1'b1 || chunk_mask !== exp || chunk_idx !== 2'(j) ||
                last_chunk !== 1'(j == N-1) || lane_ready !== 4'd0 || busy !== 1'b1 ||
                (use_dir && chunk_mask !== dir_exp)) begin
                errors++;
                $display("FAIL output chunk %0d stall %0d: mask=%h idx=%0d last=%b valid=%b ready=%b required mask=%h idx=%0d last=%b",
                         j, s, chunk_mask, chunk_idx, last_chunk, chunk_valid, lane_ready,
                         exp, j, (j == N-1));
            end
            lane_valid = 4'($urandom);
            for (int k = 0; k < 4; k++) set_lane(k, {$urandom, $urandom});
            start = 1'($urandom % 2);
            unrolling_factor = 2'($urandom);
            chunk_ready = (s == stall);
            if (s == stall && j == N-1) begin
                lane_valid = 4'd0;
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        chunk_ready = 1'b0;
        checks++;
        if (chunk_valid !== 1'b0 || busy !== 1'(j != N-1)) begin
            errors++;
            $display("FAIL after_accept chunk %0d: valid=%b busy=%b required 0/%b",
                     j, chunk_valid, busy, (j != N-1));
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (chunk_valid !== 1'b0 || lane_ready !== 4'd0 || chunk_mask !== '0 ||
            chunk_idx !== 2'd0 || last_chunk !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: valid=%b ready=%b mask=%h idx=%0d last=%b busy=%b required all 0",
                     name, chunk_valid, lane_ready, chunk_mask, chunk_idx, last_chunk, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_values");
`ifdef ACTIVE_MASK_GATHER_ERR_EN
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: err=%b required 0", err); end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_uf0();
        do_start(2'd0);
        for (int k = 0; k < 4; k++) begin
            cur_mask[k] = 64'h1111_1111_1111_1111 * (k + 1);
            cur_arr[k]  = 0;
        end
        collect_and_emit(0, 2'd0, 1, 1'b1, {cur_mask[3], cur_mask[2], cur_mask[1], cur_mask[0]});
        for (int j = 1; j < N; j++) begin
            rand_chunk();
            collect_and_emit(j, 2'd0, $urandom_range(0, 2), 1'b0, '0);
        end
    endtask

    task automatic test_uf2();
        do_start(2'd2);
        cur_mask[0] = 64'hFF; cur_mask[1] = '0; cur_mask[2] = '0; cur_mask[3] = '0;
        for (int k = 0; k < 4; k++) cur_arr[k] = $urandom_range(0, 3);
        collect_and_emit(0, 2'd2, 0, 1'b1, 256'hFF);
        cur_mask[0] = '0; cur_mask[1] = 64'hFF00;
        collect_and_emit(1, 2'd2, 0, 1'b1, 256'hFF << 40);
        for (int j = 2; j < N; j++) begin
            rand_chunk();
            collect_and_emit(j, 2'd2, $urandom_range(0, 2), 1'b0, '0);
        end
    endtask

    task automatic test_uf1_staggered();
        do_start(2'd1);
        cur_mask[0] = '0; cur_mask[1] = '0; cur_mask[2] = '0; cur_mask[3] = 64'hFFFF;
        cur_arr[2] = 0; cur_arr[0] = 3; cur_arr[3] = 5; cur_arr[1] = 6;
        collect_and_emit(0, 2'd1, 0, 1'b1, 256'hFFFF << 144);
        for (int j = 1; j < N; j++) begin
            rand_chunk();
            collect_and_emit(j, 2'd1, $urandom_range(0, 2), 1'b0, '0);
        end
    endtask

    task automatic test_stall();
        logic [1:0] u;
        u = 2'($urandom_range(0, 2));
        do_start(u);
        for (int j = 0; j < N; j++) begin
            rand_chunk();
            collect_and_emit(j, u, 10, 1'b0, '0);
        end
        check_all_zero("idle_after_op");
`ifdef ACTIVE_MASK_GATHER_ERR_EN
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clean: err=%b required 0", err); end
`endif
    endtask

    task automatic test_reset_mid_collect();
        logic [1:0] u;
        do_start(2'd1);
        rand_chunk();
        lane_valid = 4'b0011;
        lane_mask0 = cur_mask[0]; lane_mask1 = cur_mask[1];
        @(posedge clk); #1;
        lane_valid = 4'd0;
        checks++;
        if (lane_ready !== 4'b1100) begin
            errors++;
            $display("FAIL mid_collect_ready: lane_ready=%b required 1100", lane_ready);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_mid_collect");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle_after_mid_reset");
        u = 2'($urandom_range(0, 2));
        do_start(u);
        for (int j = 0; j < N; j++) begin
            rand_chunk();
            collect_and_emit(j, u, $urandom_range(0, 2), 1'b0, '0);
        end
    endtask

    task automatic test_idle_noise_and_uf3();
        for (int c = 0; c < 3; c++) begin
            lane_valid = 4'($urandom_range(1, 15));
            @(posedge clk); #1;
            check_all_zero("idle_lane_noise");
        end
        lane_valid = 4'd0;
        do_start(2'b11);
        for (int j = 0; j < N; j++) begin
            rand_chunk();
            collect_and_emit(j, 2'd0, $urandom_range(0, 1), 1'b0, '0);
        end
`ifdef ACTIVE_MASK_GATHER_ERR_EN
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: err=%b required 1", err); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [1:0] u;
        for (int op = 0; op < 6; op++) begin
            u = 2'($urandom);
            do_start(u);
            for (int j = 0; j < N; j++) begin
                rand_chunk();
                collect_and_emit(j, eff_uf(u), $urandom_range(0, 3), 1'b0, '0);
            end
        end
        check_all_zero("idle_at_end");
    endtask

    initial begin
        test_reset();
        test_uf0();
        test_uf2();
        test_uf1_staggered();
        test_stall();
        test_reset_mid_collect();
        test_idle_noise_and_uf3();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
